pc_fetch: RTL and testbench

Program-counter and instruction-fetch unit that sits directly downstream of the CPU control sequencer. It consumes the sequencer's `pc_op` command and fetch strobes, owns the 16-bit program counter, and runs the read handshake with instruction memory. It latches the instruction word and the optional immediate word for decode. While a memory read is outstanding it raises a stall, which the top level uses to gate the sequencer's `en`.

---
 rtl/pc_fetch.sv | 116 +++++++++++
 tb/tb_pc_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch unit.
// Owns the 16-bit PC and runs a single-outstanding read handshake with
// instruction memory, latching either the instruction word or the
// immediate word. A combinational stall holds the sequencer while a
// read is in flight so that the PC only moves once the read is done.

package pc_fetch_pkg;
  typedef enum logic [1:0] {
    PC_NOP   = 2'd0,
    PC_INC   = 2'd1,
    PC_SET   = 2'd2,
    PC_RESET = 2'd3
  } pc_op_e;
endpackage

module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          PC_STEP      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pc_op,
  input  logic [15:0] pc_in,
  input  logic        fetch_instr,
  input  logic        fetch_imm,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data_i,
  input  logic        mem_ready,
  output logic [15:0] instr_o,
  output logic [15:0] imm_o,
  output logic [15:0] pc_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [15:0] STEP = 16'(PC_STEP);

  state_e state;
  logic   dest_imm;   // 1: current read targets imm_o, 0: instr_o
  logic   req;
  pc_op_e op;

  assign op  = pc_op_e'(pc_op);
  assign req = en & (fetch_instr | fetch_imm);

  // Stall is raised in the accepting IDLE cycle already, so the PC update
  // that accompanies a fetch strobe is deferred until DONE.
  assign stall_o = (state == S_BUSY) | ((state == S_IDLE) & req);

  // Fetch FSM: accept a strobe, hold the address while the read is
  // outstanding, capture the returned word into its destination.
  // NOTE: all state here is assigned with <= so every register samples
  // the pre-edge values; blocking = would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= 16'h0000;
      instr_o  <= 16'h0000;
      imm_o    <= 16'h0000;
      dest_imm <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            mem_addr <= pc_o;
            dest_imm <= ~fetch_instr;  // instruction wins when both strobes are high
            mem_rd   <= 1'b1;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          // en is deliberately not consulted: an issued read always completes
          if (mem_ready) begin
            if (dest_imm) imm_o   <= mem_data_i;
            else          instr_o <= mem_data_i;
            mem_rd <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Program counter: moves only when the sequencer is enabled and not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o <= RESET_VECTOR;
    end else if (en && !stall_o) begin
      case (op)
        PC_NOP:   pc_o <= pc_o;
        PC_INC:   pc_o <= pc_o + STEP;          // wraps modulo 2^16
        PC_SET:   pc_o <= {pc_in[15:1], 1'b0};  // force word alignment
        PC_RESET: pc_o <= RESET_VECTOR;
        default:  pc_o <= pc_o;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch with hand-computed expectations.
// Inputs are driven at the falling edge; outputs are sampled 1 ns later,
// well away from the rising edge.

module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pc_op;
  logic [15:0] pc_in;
  logic        fetch_instr;
  logic        fetch_imm;
  logic [15:0] mem_data_i;
  logic        mem_ready;

  logic        mem_rd,  mem_rd_b;
  logic [15:0] mem_addr, mem_addr_b;
  logic [15:0] instr_o, instr_o_b;
  logic [15:0] imm_o,   imm_o_b;
  logic [15:0] pc_o,    pc_o_b;
  logic        stall_o, stall_o_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .rst(rst), .en(en), .pc_op(pc_op), .pc_in(pc_in),
    .fetch_instr(fetch_instr), .fetch_imm(fetch_imm),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data_i(mem_data_i),
    .mem_ready(mem_ready), .instr_o(instr_o), .imm_o(imm_o),
    .pc_o(pc_o), .stall_o(stall_o)
  );

  // Second instance only exercises a non-zero reset vector.
  pc_fetch #(.RESET_VECTOR(16'h0100)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pc_op(pc_op), .pc_in(pc_in),
    .fetch_instr(fetch_instr), .fetch_imm(fetch_imm),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data_i(mem_data_i),
    .mem_ready(mem_ready), .instr_o(instr_o_b), .imm_o(imm_o_b),
    .pc_o(pc_o_b), .stall_o(stall_o_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Load the PC through PC_SET with no strobe and confirm one-cycle update.
  task automatic set_pc(input logic [15:0] target, input string tag);
    @(negedge clk);
    pc_op = PC_SET;
    pc_in = target;
    @(negedge clk);
    pc_op = PC_NOP;
    #1;
    check(tag, pc_o, {target[15:1], 1'b0});
  endtask

  // One fetch with PC_INC held until DONE; mem_ready arrives on BUSY cycle delay+1.
  task automatic run_fetch(input bit is_imm, input int delay, input logic [15:0] data,
                           output int stall_cnt, output int rd_cnt,
                           output logic [15:0] addr, output bit addr_ok, output bit done);
    int busy = 0;
    stall_cnt = 0;
    rd_cnt    = 0;
    addr      = 16'hxxxx;
    addr_ok   = 1'b1;
    done      = 1'b0;
    @(negedge clk);
    fetch_instr = ~is_imm;
    fetch_imm   = is_imm;
    pc_op       = PC_INC;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (stall_o) stall_cnt++;
      mem_ready  = 1'b0;
      mem_data_i = 16'hBAD0;
      if (mem_rd) begin
        busy++;
        if (busy == 1) addr = mem_addr;
        else if (mem_addr !== addr) addr_ok = 1'b0;
        if (busy == delay + 1) begin
          mem_ready  = 1'b1;
          mem_data_i = data;
        end
      end else if (busy > 0) begin
        done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    rd_cnt    = busy;
    mem_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          stall_cnt, rd_cnt;
    logic [15:0] addr;
    bit          addr_ok, done;

    rst = 1'b1; en = 1'b0; pc_op = PC_NOP; pc_in = 16'h0000;
    fetch_instr = 1'b0; fetch_imm = 1'b0; mem_data_i = 16'h0000; mem_ready = 1'b0;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pc",       pc_o,     16'h0000);
    check("rst_pc_vec",   pc_o_b,   16'h0100);
    check("rst_mem_rd",   16'(mem_rd), 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_instr",    instr_o,  16'h0000);
    check("rst_imm",      imm_o,    16'h0000);
    check("rst_stall",    16'(stall_o), 16'h0000);

    en = 1'b1;
    set_pc(16'h0010, "set_pc_0010");

    // Instruction fetch, zero wait states
    run_fetch(1'b0, 0, 16'hA5C3, stall_cnt, rd_cnt, addr, addr_ok, done);
    check("if_done",      16'(done),      16'h0001);
    check("if_addr",      addr,           16'h0010);
    check("if_rd_cycles", 16'(rd_cnt),    16'h0001);
    check("if_stall_cyc", 16'(stall_cnt), 16'h0002);
    check("if_instr",     instr_o,        16'hA5C3);
    check("if_imm_kept",  imm_o,          16'h0000);
    check("if_pc_in_done", pc_o,          16'h0010);
    @(negedge clk);
    fetch_instr = 1'b0; pc_op = PC_NOP;
    #1;
    check("if_pc_after",  pc_o,           16'h0012);
    check("if_idle_stall", 16'(stall_o),  16'h0000);

    // Immediate fetch with three wait states
    run_fetch(1'b1, 3, 16'h1234, stall_cnt, rd_cnt, addr, addr_ok, done);
    check("imm_done",       16'(done),      16'h0001);
    check("imm_addr",       addr,           16'h0012);
    check("imm_addr_stable", 16'(addr_ok),  16'h0001);
    check("imm_rd_cycles",  16'(rd_cnt),    16'h0004);
    check("imm_stall_cyc",  16'(stall_cnt), 16'h0005);
    check("imm_value",      imm_o,          16'h1234);
    check("imm_instr_kept", instr_o,        16'hA5C3);
    @(negedge clk);
    fetch_imm = 1'b0; pc_op = PC_NOP;
    #1;
    check("imm_pc_after",   pc_o,           16'h0014);
    @(negedge clk);
    #1;
    check("imm_pc_hold",    pc_o,           16'h0014);

    // Disabled sequencer: PC_INC must not move the PC
    @(negedge clk);
    en = 1'b0; pc_op = PC_INC;
    @(negedge clk);
    #1;
    check("en_low_hold", pc_o, 16'h0014);
    en = 1'b1; pc_op = PC_NOP;

    // Branch: odd target is word-aligned
    set_pc(16'h4567, "branch_pc");

    // Wrap at the top of the address space
    set_pc(16'hFFFE, "set_pc_fffe");
    @(negedge clk);
    pc_op = PC_INC;
    @(negedge clk);
    pc_op = PC_NOP;
    #1;
    check("wrap_pc", pc_o, 16'h0000);

    // PC_RESET op returns to the reset vector
    set_pc(16'h2222, "set_pc_2222");
    @(negedge clk);
    pc_op = PC_RESET;
    @(negedge clk);
    pc_op = PC_NOP;
    #1;
    check("pc_reset_op",     pc_o,   16'h0000);
    check("pc_reset_op_vec", pc_o_b, 16'h0100);

    // Reset during the second BUSY cycle, late mem_ready must be dropped
    set_pc(16'h0020, "set_pc_0020");
    @(negedge clk);                      // c0: IDLE, strobe
    fetch_instr = 1'b1; pc_op = PC_INC;
    @(negedge clk);                      // c1: first BUSY
    #1;
    check("mid_busy_rd", 16'(mem_rd), 16'h0001);
    @(negedge clk);                      // c2: second BUSY, reset asserted
    rst = 1'b1;
    @(negedge clk);                      // c3: after reset, late ready
    rst = 1'b0; fetch_instr = 1'b0; pc_op = PC_NOP;
    mem_ready = 1'b1; mem_data_i = 16'h9999;
    #1;
    check("mid_rst_rd",    16'(mem_rd),  16'h0000);
    check("mid_rst_pc",    pc_o,         16'h0000);
    check("mid_rst_stall", 16'(stall_o), 16'h0000);
    @(negedge clk);
    mem_ready = 1'b0; mem_data_i = 16'h0000;
    #1;
    check("mid_rst_instr",   instr_o,      16'h0000);
    check("mid_rst_rd_late", 16'(mem_rd),  16'h0000);
    check("mid_rst_idle",    16'(stall_o), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
